command_frame_tx: RTL and testbench
===================================

Name: command_frame_tx

Overview:
Initiator side of the 8-byte command frame link. Builds command frames (EB 90 | src | dest | code | csum | 09 D7) and pushes them byte-by-byte into the UART transmit FIFO. It then reads the 8-byte echo that the responder returns through the UART receive FIFO and checks it. Sits between the control logic (cmd_* handshake) and the UART core's FIFO interface; used by the control-center / test-controller build.

Parameters:
CNT_W, 5, width of UART FIFO counters (matches the UART core's FIFO counter width).
FIFO_DEPTH, 16, transmit FIFO depth in bytes.
GAP, 3, idle cycles after every tf_push/rf_pop before the next FIFO access.
TIMEOUT, 100000, cycles to wait for a complete echo; 32-bit internal counter.
MAX_RETRY, 2, resends after an echo failure or timeout (0 = no resend).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
cmd_valid  in  1  request to send; sampled only when cmd_ready=1.
cmd_ready  out  1  high in IDLE only.
cmd_src  in  8  frame byte 2.
cmd_dest  in  8  frame byte 3 (8'hAB = switch board).
cmd_code  in  8  frame byte 4 (e.g. 8'h0A, 8'h0B, 8'hA0, 8'hB0).
tf_counter  in  CNT_W  current transmit FIFO fill level.
tf_push  out  1  one-cycle push strobe; tdr is valid in the same cycle.
tdr  out  8  byte to the transmit FIFO.
rf_counter  in  CNT_W  current receive FIFO fill level.
rdr  in  8  receive FIFO head byte.
rf_pop  out  1  one-cycle pop strobe.
done  out  1  one-cycle pulse when a transaction ends.
ack_ok  out  1  valid with done: echo matched.
timeout  out  1  valid with done: echo not received within the limit on the final attempt.
retry_cnt  out  2  resends used by the last transaction.

Behaviour:
- Reset (rst=1 at posedge): state IDLE; cmd_ready=1; tf_push=0; rf_pop=0; tdr=0; done=0; ack_ok=0; timeout=0; retry_cnt=0; frame registers=0; all counters=0. Reset in the middle of a frame aborts it immediately. Bytes already pushed to the FIFO stay there.
- Frame latching: on cmd_valid & cmd_ready, latch the frame: f0=EB, f1=90, f2=src, f3=dest, f4=code, f5=(0-(src+dest+code)) mod 256, f6=09, f7=D7. The sum f2+f3+f4+f5 is 0 mod 256. cmd_ready drops the next cycle.
- States:
  - IDLE -> ROOM on accept.
  - ROOM: wait until FIFO_DEPTH-tf_counter >= 8, then -> PUSH with idx=0. The whole frame is guaranteed to fit; no partial frame is ever pushed.
  - PUSH: tdr=f[idx], tf_push=1 for one cycle, idx+1, -> GAP.
  - GAP: hold tf_push/rf_pop=0 for GAP cycles. Then -> PUSH if idx<8, else -> ECHO (after the last push; tmo counter cleared), or -> POP if popping the echo.
  - ECHO: wait for rf_counter>=8 -> POP with idx=0 and mismatch=0. tmo increments each cycle; when tmo reaches TIMEOUT -> FAIL.
  - POP: compare rdr with f[idx] and set the mismatch flag on any difference. Pulse rf_pop, idx+1, -> GAP. After the 8th pop -> DONE_OK if mismatch=0, else FAIL.
  - FAIL: if retry_cnt<MAX_RETRY, increment retry_cnt and go -> ROOM (resend the same latched frame). Otherwise -> DONE with ack_ok=0, and timeout=1 if the last attempt timed out.
  - DONE_OK/DONE: pulse done for one cycle, -> IDLE. ack_ok and timeout hold until the next accept. retry_cnt clears on accept.
- Bytes are compared before they are popped: rdr shows the head entry, and the GAP delay covers the FIFO read latency.
- Garbage in the RX FIFO at send time is not flushed. It shows up as a mismatch and leads to a retry. Each retry pops exactly 8 bytes.
- tf_push and rf_pop are never high in the same cycle, and never high in two consecutive cycles.
- The responder echoes an invalid frame as well (it sets its own error), so ack_ok reports only that the link round-trip succeeded.

Test Plan:
1. Send src=01, dest=AB, code=0A; tf_counter=0; loop tdr back into rdr via a model FIFO -> pushes EB 90 01 AB 0A 4A 09 D7, each separated by 3 idle cycles; done with ack_ok=1, retry_cnt=0.
2. tf_counter=9, FIFO_DEPTH=16 -> no push until tf_counter drops to 8, then 8 pushes back-to-back with GAP spacing.
3. Echo byte 4 corrupted to 0B on the first attempt only -> one resend; done with ack_ok=1, retry_cnt=1.
4. No echo at all, TIMEOUT=50, MAX_RETRY=2 -> the frame is pushed 3 times (24 pushes); done with ack_ok=0, timeout=1, retry_cnt=2.
5. cmd_valid held high while busy -> ignored; exactly one frame sent; a new request is accepted only after done.
6. Assert rst during push index 4 -> next cycle tf_push=0, cmd_ready=1, all outputs at reset values; a new command then sends a full correct frame.

Source files
------------

// File: rtl/command_frame_if.sv
// command_frame_if
//   Bundles the control-side command handshake and the UART FIFO signals of
//   the command frame initiator.
//   master : the frame transmitter (drives cmd_ready, tf_push/tdr, rf_pop,
//            done/ack_ok/timeout/retry_cnt).
//   slave  : the surroundings (control logic plus UART FIFOs).
//   Command : cmd_valid, cmd_ready, cmd_src, cmd_dest, cmd_code
//   TX FIFO : tf_counter, tf_push, tdr
//   RX FIFO : rf_counter, rdr, rf_pop
//   Status  : done, ack_ok, timeout, retry_cnt
interface command_frame_if #(
  parameter int CNT_W = 5
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_src;
  logic [7:0]       cmd_dest;
  logic [7:0]       cmd_code;
  logic [CNT_W-1:0] tf_counter;
  logic             tf_push;
  logic [7:0]       tdr;
  logic [CNT_W-1:0] rf_counter;
  logic [7:0]       rdr;
  logic             rf_pop;
  logic             done;
  logic             ack_ok;
  logic             timeout;
  logic [1:0]       retry_cnt;

  modport master (
    input  cmd_valid, cmd_src, cmd_dest, cmd_code, tf_counter, rf_counter, rdr,
    output cmd_ready, tf_push, tdr, rf_pop, done, ack_ok, timeout, retry_cnt
  );

  modport slave (
    output cmd_valid, cmd_src, cmd_dest, cmd_code, tf_counter, rf_counter, rdr,
    input  cmd_ready, tf_push, tdr, rf_pop, done, ack_ok, timeout, retry_cnt
  );
endinterface

// File: rtl/command_frame_tx.sv
// command_frame_tx
//   Initiator of the 8-byte command frame link. Latches a command, builds
//   EB 90 | src | dest | code | csum | 09 D7, pushes it into the UART TX FIFO
//   one byte at a time with GAP idle cycles between FIFO accesses, then pops
//   and checks the 8-byte echo from the RX FIFO. Failed or missing echoes are
//   retried up to MAX_RETRY times with the same latched frame.
//   Ports: clk, rst (sync, active-high), bus (command_frame_if.master).
module command_frame_tx #(
  parameter int CNT_W      = 5,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP        = 3,
  parameter int TIMEOUT    = 100000,
  parameter int MAX_RETRY  = 2
) (
  input  logic             clk,
  input  logic             rst,
  command_frame_if.master  bus
);

  localparam int               GAP_W     = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP - 1);
  // Free space >= 8 rewritten as a fill-level bound to avoid signed math.
  localparam logic [CNT_W-1:0] ROOM_MAX  = CNT_W'(FIFO_DEPTH - 8);
  localparam logic [CNT_W-1:0] ECHO_NEED = CNT_W'(8);

  typedef enum logic [3:0] {
    S_IDLE, S_ROOM, S_PUSH, S_GAP, S_ECHO, S_POP, S_FAIL, S_DONE_OK, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [31:0] tmo_q, tmo_d;
  logic        popping_q, popping_d;    // GAP returns to POP instead of PUSH
  logic        mismatch_q, mismatch_d;
  logic        timed_out_q, timed_out_d; // outcome of the latest attempt
  logic [1:0]  retry_q, retry_d;
  logic        ack_ok_q, ack_ok_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  frame_q [8];
  logic [7:0]  frame_d [8];

  // Byte that makes src+dest+code+csum == 0 mod 256.
  function automatic logic [7:0] csum8(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
    logic [7:0] s;
    s = a + b + c;
    return 8'h00 - s;
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    tmo_d       = tmo_q;
    popping_d   = popping_q;
    mismatch_d  = mismatch_q;
    timed_out_d = timed_out_q;
    retry_d     = retry_q;
    ack_ok_d    = ack_ok_q;
    timeout_d   = timeout_q;
    frame_d     = frame_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          frame_d[0]  = 8'hEB;
          frame_d[1]  = 8'h90;
          frame_d[2]  = bus.cmd_src;
          frame_d[3]  = bus.cmd_dest;
          frame_d[4]  = bus.cmd_code;
          frame_d[5]  = csum8(bus.cmd_src, bus.cmd_dest, bus.cmd_code);
          frame_d[6]  = 8'h09;
          frame_d[7]  = 8'hD7;
          retry_d     = 2'd0;
          ack_ok_d    = 1'b0;
          timeout_d   = 1'b0;
          timed_out_d = 1'b0;
          state_d     = S_ROOM;
        end
      end
      S_ROOM: begin
        // Only start once all 8 bytes fit, so a frame is never split.
        if (bus.tf_counter <= ROOM_MAX) begin
          idx_d     = 4'd0;
          popping_d = 1'b0;
          state_d   = S_PUSH;
        end
      end
      S_PUSH: begin
        idx_d   = idx_q + 4'd1;
        gap_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (idx_q != 4'd8) begin
            state_d = popping_q ? S_POP : S_PUSH;
          end else if (popping_q) begin
            if (mismatch_q) begin
              state_d = S_FAIL;
            end else begin
              ack_ok_d  = 1'b1;
              timeout_d = 1'b0;
              state_d   = S_DONE_OK;
            end
          end else begin
            tmo_d   = 32'd0;
            state_d = S_ECHO;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_ECHO: begin
        if (bus.rf_counter >= ECHO_NEED) begin
          idx_d       = 4'd0;
          mismatch_d  = 1'b0;
          popping_d   = 1'b1;
          timed_out_d = 1'b0;
          state_d     = S_POP;
        end else begin
          tmo_d = tmo_q + 32'd1;
          if (tmo_d == 32'(TIMEOUT)) begin
            timed_out_d = 1'b1;
            state_d     = S_FAIL;
          end
        end
      end
      S_POP: begin
        // rdr already shows the head entry; compare before it is popped.
        mismatch_d = mismatch_q | (bus.rdr != frame_q[idx_q[2:0]]);
        idx_d      = idx_q + 4'd1;
        gap_d      = '0;
        state_d    = S_GAP;
      end
      S_FAIL: begin
        if (retry_q < 2'(MAX_RETRY)) begin
          retry_d = retry_q + 2'd1;
          state_d = S_ROOM;
        end else begin
          ack_ok_d  = 1'b0;
          timeout_d = timed_out_q;
          state_d   = S_DONE;
        end
      end
      S_DONE_OK, S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      gap_q       <= '0;
      tmo_q       <= '0;
      popping_q   <= 1'b0;
      mismatch_q  <= 1'b0;
      timed_out_q <= 1'b0;
      retry_q     <= '0;
      ack_ok_q    <= 1'b0;
      timeout_q   <= 1'b0;
      frame_q     <= '{default: 8'h00};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      tmo_q       <= tmo_d;
      popping_q   <= popping_d;
      mismatch_q  <= mismatch_d;
      timed_out_q <= timed_out_d;
      retry_q     <= retry_d;
      ack_ok_q    <= ack_ok_d;
      timeout_q   <= timeout_d;
      frame_q     <= frame_d;
    end
  end

  // Strobes are decoded from the state, so PUSH/POP always last one cycle
  // and are separated by at least one GAP cycle.
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.tf_push   = (state_q == S_PUSH);
  assign bus.tdr       = (state_q == S_PUSH) ? frame_q[idx_q[2:0]] : 8'h00;
  assign bus.rf_pop    = (state_q == S_POP);
  assign bus.done      = (state_q == S_DONE_OK) || (state_q == S_DONE);
  assign bus.ack_ok    = ack_ok_q;
  assign bus.timeout   = timeout_q;
  assign bus.retry_cnt = retry_q;

endmodule

// File: tb/tb_command_frame_tx.sv
// tb_command_frame_tx
//   Directed bench for command_frame_tx: loops pushed bytes back into a model
//   RX FIFO (optionally corrupting one byte or dropping the echo) and checks
//   pushed bytes, push spacing, handshake and status outputs.
module tb_command_frame_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  command_frame_if #(.CNT_W(5)) bus ();

  command_frame_tx #(
    .CNT_W(5), .FIFO_DEPTH(16), .GAP(3), .TIMEOUT(50), .MAX_RETRY(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Environment model: push log and loopback RX FIFO.
  int         cyc = 0;
  logic [7:0] push_log[$];
  int         push_cyc[$];
  logic [7:0] rxq[$];
  logic       loop_en = 1'b1;
  int         corrupt_pos = -1;
  logic       pend_pop = 1'b0;
  logic [4:0] rf_cnt_v = 5'd0;
  logic [7:0] rdr_v = 8'h00;

  assign bus.rf_counter = rf_cnt_v;
  assign bus.rdr        = rdr_v;

  always @(posedge clk) cyc++;

  // A pop takes effect after the edge that consumed the head byte.
  always @(negedge clk) begin
    if (pend_pop && rxq.size() > 0) void'(rxq.pop_front());
    pend_pop = bus.rf_pop;
    if (bus.tf_push === 1'b1) begin
      push_log.push_back(bus.tdr);
      push_cyc.push_back(cyc);
      if (loop_en) begin
        if (push_log.size() - 1 == corrupt_pos) rxq.push_back(8'h0B);
        else rxq.push_back(bus.tdr);
      end
    end
    rf_cnt_v = 5'(rxq.size());
    rdr_v    = (rxq.size() > 0) ? rxq[0] : 8'h00;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] s, input logic [7:0] d, input logic [7:0] c);
    bus.cmd_src   = s;
    bus.cmd_dest  = d;
    bus.cmd_code  = c;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $error("FAIL %s_wait expired after %0d cycles", tag, budget);
    end
    chk({tag, "_done"}, bus.done, 1'b1);
  endtask

  task automatic check_frame(input int base, input logic [63:0] exp, input string tag);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      e = exp[63-8*i -: 8];
      chk($sformatf("%s_b%0d", tag, i), push_log[base+i], e);
    end
  endtask

  task automatic check_spacing(input int base, input string tag);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("%s_gap%0d", tag, i), push_cyc[base+i+1] - push_cyc[base+i], 4);
    end
  endtask

  initial begin
    int base;
    int n;
    int k;
    bus.cmd_valid  = 1'b0;
    bus.cmd_src    = 8'h00;
    bus.cmd_dest   = 8'h00;
    bus.cmd_code   = 8'h00;
    bus.tf_counter = 5'd0;

    // Reset values
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk("rst_tf_push", bus.tf_push, 1'b0);
    chk("rst_rf_pop", bus.rf_pop, 1'b0);
    chk("rst_tdr", bus.tdr, 8'h00);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_ack_ok", bus.ack_ok, 1'b0);
    chk("rst_timeout", bus.timeout, 1'b0);
    chk("rst_retry", bus.retry_cnt, 2'd0);
    rst = 1'b0;
    tick();

    // 1: basic frame with loopback echo
    base = push_log.size();
    send(8'h01, 8'hAB, 8'h0A);
    chk("t1_ready_drop", bus.cmd_ready, 1'b0);
    wait_done(500, "t1");
    chk("t1_ack_ok", bus.ack_ok, 1'b1);
    chk("t1_timeout", bus.timeout, 1'b0);
    chk("t1_retry", bus.retry_cnt, 2'd0);
    chk("t1_npush", push_log.size() - base, 8);
    check_frame(base, 64'hEB90_01AB_0A4A_09D7, "t1");
    check_spacing(base, "t1");
    tick();
    chk("t1_idle_ready", bus.cmd_ready, 1'b1);
    chk("t1_ack_hold", bus.ack_ok, 1'b1);

    // 2: TX FIFO too full, then exactly enough room
    bus.tf_counter = 5'd9;
    base = push_log.size();
    send(8'h05, 8'hAB, 8'h0B);
    repeat (20) tick();
    chk("t2_no_push_full", push_log.size() - base, 0);
    bus.tf_counter = 5'd8;
    wait_done(500, "t2");
    bus.tf_counter = 5'd0;
    chk("t2_ack_ok", bus.ack_ok, 1'b1);
    chk("t2_npush", push_log.size() - base, 8);
    check_frame(base, 64'hEB90_05AB_0B45_09D7, "t2");
    check_spacing(base, "t2");
    tick();

    // 3: echo byte 4 corrupted once -> one resend
    base = push_log.size();
    corrupt_pos = base + 4;
    send(8'h01, 8'hAB, 8'h0A);
    wait_done(1000, "t3");
    corrupt_pos = -1;
    chk("t3_ack_ok", bus.ack_ok, 1'b1);
    chk("t3_timeout", bus.timeout, 1'b0);
    chk("t3_retry", bus.retry_cnt, 2'd1);
    chk("t3_npush", push_log.size() - base, 16);
    check_frame(base + 8, 64'hEB90_01AB_0A4A_09D7, "t3_resend");
    chk("t3_rx_empty", rxq.size(), 0);
    tick();

    // 4: no echo -> 3 attempts, timeout
    loop_en = 1'b0;
    base = push_log.size();
    send(8'h01, 8'hAB, 8'h0A);
    wait_done(2000, "t4");
    chk("t4_ack_ok", bus.ack_ok, 1'b0);
    chk("t4_timeout", bus.timeout, 1'b1);
    chk("t4_retry", bus.retry_cnt, 2'd2);
    chk("t4_npush", push_log.size() - base, 24);
    check_frame(base + 16, 64'hEB90_01AB_0A4A_09D7, "t4_last");
    loop_en = 1'b1;
    tick();

    // 5: cmd_valid held high while busy, inputs changed after accept
    base = push_log.size();
    bus.cmd_src   = 8'h02;
    bus.cmd_dest  = 8'hAB;
    bus.cmd_code  = 8'hA0;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_src = 8'h55;
    chk("t5_busy_ready", bus.cmd_ready, 1'b0);
    chk("t5_clear_timeout", bus.timeout, 1'b0);
    wait_done(500, "t5");
    bus.cmd_valid = 1'b0;
    chk("t5_ack_ok", bus.ack_ok, 1'b1);
    chk("t5_retry", bus.retry_cnt, 2'd0);
    chk("t5_npush", push_log.size() - base, 8);
    check_frame(base, 64'hEB90_02AB_A0B3_09D7, "t5");
    tick();
    chk("t5_ready_after", bus.cmd_ready, 1'b1);
    repeat (10) tick();
    chk("t5_no_extra", push_log.size() - base, 8);

    // 6: reset during push index 4, then a clean frame
    loop_en = 1'b0;
    send(8'h01, 8'hAB, 8'h0A);
    n = 0;
    k = 0;
    while (n < 200) begin
      if (bus.tf_push === 1'b1) begin
        if (k == 4) break;
        k++;
      end
      tick();
      n++;
    end
    chk("t6_at_push4", bus.tdr, 8'h0A);
    rst = 1'b1;
    tick();
    chk("t6_tf_push", bus.tf_push, 1'b0);
    chk("t6_cmd_ready", bus.cmd_ready, 1'b1);
    chk("t6_tdr", bus.tdr, 8'h00);
    chk("t6_rf_pop", bus.rf_pop, 1'b0);
    chk("t6_done", bus.done, 1'b0);
    chk("t6_ack_ok", bus.ack_ok, 1'b0);
    chk("t6_retry", bus.retry_cnt, 2'd0);
    rst = 1'b0;
    loop_en = 1'b1;
    tick();
    base = push_log.size();
    send(8'h03, 8'hAB, 8'hB0);
    wait_done(500, "t6b");
    chk("t6b_ack_ok", bus.ack_ok, 1'b1);
    chk("t6b_retry", bus.retry_cnt, 2'd0);
    chk("t6b_npush", push_log.size() - base, 8);
    check_frame(base, 64'hEB90_03AB_B0A2_09D7, "t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
